branch_pred_ctrl_unit: RTL and testbench
========================================

Name: branch_pred_ctrl_unit

Overview:
- Next-generation branch control unit: resolves conditional branches and JAL/JALR in EX, as before, and adds a parametrised bimodal direction predictor used in ID.
- Predictor is a table of 2-bit saturating counters indexed by PC. ID redirects predicted-taken branches early; EX detects mispredictions and issues PC recovery plus pipeline flush.
- Also keeps saturating branch and mispredict event counters for performance analysis.

Parameters:
- XLEN, 32, PC width in bits.
- IDX_W, 6, predictor index width; table depth = 2^IDX_W entries.
- PRED_MODE, 1, 0 = static not-taken (table unused), 1 = bimodal 2-bit counters.
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_stall  in  1  pipeline stall; blocks table and counter updates.
- i_id_branch  in  1  ID instruction is a conditional branch.
- i_id_pc  in  XLEN  PC of the ID instruction.
- o_pred_taken  out  1  prediction for the ID branch; travels down the pipe with the instruction.
- o_id_redirect  out  1  ID redirects fetch to PC+imm and flushes IF/ID.
- i_ex_valid  in  1  EX instruction is valid (not a bubble).
- i_ex_branch  in  1  EX instruction is a conditional branch.
- i_ex_jump  in  1  EX instruction is JAL or JALR.
- i_ex_linkReg  in  1  EX instruction is JALR.
- i_ex_func3_0  in  1  func3[0] of the EX instruction.
- i_ex_func3_2  in  1  func3[2] of the EX instruction.
- i_alu_result  in  1  ALU result bit 0 (SLT/SLTU outcome).
- i_alu_zero  in  1  ALU zero flag.
- i_ex_pc  in  XLEN  PC of the EX instruction.
- i_ex_pred_taken  in  1  prediction carried with the EX instruction.
- o_pcSrc  out  2  00 = PC+4, 01 = PC+imm, 10 = rs1+imm, 11 = EX PC+4 (recovery).
- o_flush  out  1  flush IF/ID and ID/EX.
- o_branch_cnt  out  CNT_W  resolved conditional branches.
- o_mispred_cnt  out  CNT_W  mispredicted conditional branches.

Behaviour:
- Reset (asynchronous, active-low):
  - every table entry = 2'b01 (weakly not-taken);
  - both counters = 0;
  - all combinational outputs then follow the reset state: o_pred_taken = 0, o_id_redirect = 0, o_pcSrc = 00, o_flush = 0 with no EX activity.
- Index: idx = PC[IDX_W+1:2] for both lookup and update.
- Lookup (combinational, same cycle):
  - o_pred_taken = i_id_branch & (PRED_MODE == 1) & table[idx_id][1];
  - o_id_redirect = o_pred_taken & ~o_flush. An EX flush always overrides an ID redirect.
- Actual direction (combinational; requires i_ex_valid & i_ex_branch):
  - func3_2 = 0: taken = func3_0 ? ~zero : zero (BEQ/BNE);
  - func3_2 = 1: taken = func3_0 ? ~result : result (BLT/BLTU, BGE/BGEU);
  - mispredict = taken XOR i_ex_pred_taken.
- o_pcSrc / o_flush priority, all combinational:
  - valid branch mispredicted and taken: 01, flush = 1;
  - valid branch mispredicted and not taken: 11, flush = 1;
  - valid branch correctly predicted: 00, flush = 0 (an ID redirect already occurred if it was taken);
  - valid JAL (jump & ~linkReg): 01, flush = 1;
  - valid JALR (jump & linkReg): 10, flush = 1;
  - otherwise: 00, flush = 0.
  - i_ex_valid = 0 forces 00 / 0.
- Table update, on the rising clock edge when i_ex_valid & i_ex_branch & ~i_stall & (PRED_MODE == 1):
  - taken increments the entry, saturating at 11;
  - not taken decrements it, saturating at 00.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value; no bypass.
- Counters, on the same update condition, regardless of PRED_MODE:
  - o_branch_cnt += 1;
  - o_mispred_cnt += mispredict;
  - both saturate at all-ones and do not wrap.
- PRED_MODE = 0: o_pred_taken is constant 0, so every taken branch mispredicts (01 + flush). This matches the previous unit exactly; the table is held at reset.
- Stall: outputs remain combinational; no state changes while i_stall = 1.
- Reset mid-operation: immediate clear of all state; outputs follow combinationally.

Test Plan:
1. After reset, branch at PC 0x40 in ID: o_pred_taken = 0. EX resolves BEQ taken with i_ex_pred_taken = 0: o_pcSrc = 01, o_flush = 1. Next cycle entry[16] = 10, o_mispred_cnt = 1, o_branch_cnt = 1.
2. Train PC 0x40 taken three times: entry saturates at 11. Next ID lookup: o_pred_taken = 1, o_id_redirect = 1. EX resolves taken with pred = 1: o_pcSrc = 00, o_flush = 0, o_mispred_cnt unchanged.
3. Predicted-taken BNE resolving not taken (zero = 1, pred = 1): o_pcSrc = 11, o_flush = 1. Entry decrements 11 -> 10.
4. JAL then JALR in EX with i_ex_valid = 1: o_pcSrc = 01 then 10, o_flush = 1 both cycles. Table and counters unchanged. With an ID branch present in the same cycle, o_id_redirect = 0.
5. i_stall = 1 during a mispredicted BGEU (result = 0, pred = 0): o_pcSrc = 01 and o_flush = 1 asserted, but table entry and counters are unchanged until stall drops.
6. PRED_MODE = 0, IDX_W = 4: 20 taken BLTs give o_pred_taken = 0 on every lookup, each resolves 01 + flush, o_mispred_cnt = 20. Separately, with CNT_W = 4, 17 branches leave o_branch_cnt saturated at 15.

Source files
------------

// File: rtl/branch_pred_ctrl_unit.sv
// Branch control with a bimodal direction predictor: ID-stage lookup/redirect,
// EX-stage resolution, misprediction recovery and saturating event counters.
module branch_pred_ctrl_unit #(
  parameter int XLEN      = 32,
  parameter int IDX_W     = 6,
  parameter int PRED_MODE = 1,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_id_branch,
  input  logic [XLEN-1:0]  i_id_pc,
  output logic             o_pred_taken,
  output logic             o_id_redirect,
  input  logic             i_ex_valid,
  input  logic             i_ex_branch,
  input  logic             i_ex_jump,
  input  logic             i_ex_linkReg,
  input  logic             i_ex_func3_0,
  input  logic             i_ex_func3_2,
  input  logic             i_alu_result,
  input  logic             i_alu_zero,
  input  logic [XLEN-1:0]  i_ex_pc,
  input  logic             i_ex_pred_taken,
  output logic [1:0]       o_pcSrc,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       tbl_q [DEPTH];
  logic [IDX_W-1:0] idx_id, idx_ex;
  logic             ex_br, taken, mispred, upd, tbl_we;
  logic [1:0]       ent_q, ent_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic             unused_pc;

  assign idx_id    = i_id_pc[IDX_W+1:2];
  assign idx_ex    = i_ex_pc[IDX_W+1:2];
  assign unused_pc = ^{i_id_pc[XLEN-1:IDX_W+2], i_id_pc[1:0],
                       i_ex_pc[XLEN-1:IDX_W+2], i_ex_pc[1:0]};

  assign o_pred_taken  = (PRED_MODE == 1) ? (i_id_branch & tbl_q[idx_id][1]) : 1'b0;
  assign o_id_redirect = o_pred_taken & ~o_flush;

  // func3[2] selects compare-based (BLT/BGE family) vs equality (BEQ/BNE) branches
  assign taken   = i_ex_func3_2 ? (i_ex_func3_0 ? ~i_alu_result : i_alu_result)
                                : (i_ex_func3_0 ? ~i_alu_zero   : i_alu_zero);
  assign ex_br   = i_ex_valid & i_ex_branch;
  assign mispred = ex_br & (taken ^ i_ex_pred_taken);
  assign upd     = ex_br & ~i_stall;
  assign tbl_we  = upd & (PRED_MODE == 1);

  always_comb begin
    o_pcSrc = 2'b00;
    o_flush = 1'b0;
    if (i_ex_valid) begin
      if (i_ex_branch) begin
        if (mispred) begin
          o_pcSrc = taken ? 2'b01 : 2'b11;
          o_flush = 1'b1;
        end
      end else if (i_ex_jump) begin
        o_pcSrc = i_ex_linkReg ? 2'b10 : 2'b01;
        o_flush = 1'b1;
      end
    end
  end

  assign ent_q = tbl_q[idx_ex];
  always_comb begin
    ent_d = ent_q;
    if (taken) begin
      if (ent_q != 2'b11) ent_d = ent_q + 2'd1;
    end else begin
      if (ent_q != 2'b00) ent_d = ent_q - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= 2'b01;
    end else if (tbl_we) begin
      tbl_q[idx_ex] <= ent_d;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd) begin
      if (branch_cnt_q != '1)             branch_cnt_d  = branch_cnt_q + 1'b1;
      if (mispred && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_pred_ctrl_unit.sv
// Directed bench for branch_pred_ctrl_unit: default bimodal instance, a static
// not-taken instance (IDX_W=4) and a narrow-counter instance (CNT_W=4).
module tb_branch_pred_ctrl_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_stall, i_id_branch;
  logic [31:0] i_id_pc, i_ex_pc;
  logic        i_ex_valid, i_ex_branch, i_ex_jump, i_ex_linkReg;
  logic        i_ex_func3_0, i_ex_func3_2, i_alu_result, i_alu_zero, i_ex_pred_taken;

  logic        pred, redir, flush;
  logic [1:0]  pcsrc;
  logic [31:0] bcnt, mcnt;
  logic        m0_pred, m0_redir, m0_flush;
  logic [1:0]  m0_pcsrc;
  logic [31:0] m0_bcnt, m0_mcnt;
  logic        c4_pred, c4_redir, c4_flush;
  logic [1:0]  c4_pcsrc;
  logic [3:0]  c4_bcnt, c4_mcnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  branch_pred_ctrl_unit u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .i_id_branch(i_id_branch), .i_id_pc(i_id_pc),
    .o_pred_taken(pred), .o_id_redirect(redir),
    .i_ex_valid(i_ex_valid), .i_ex_branch(i_ex_branch), .i_ex_jump(i_ex_jump),
    .i_ex_linkReg(i_ex_linkReg), .i_ex_func3_0(i_ex_func3_0), .i_ex_func3_2(i_ex_func3_2),
    .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_ex_pc(i_ex_pc),
    .i_ex_pred_taken(i_ex_pred_taken),
    .o_pcSrc(pcsrc), .o_flush(flush), .o_branch_cnt(bcnt), .o_mispred_cnt(mcnt)
  );

  branch_pred_ctrl_unit #(.IDX_W(4), .PRED_MODE(0)) u_m0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .i_id_branch(i_id_branch), .i_id_pc(i_id_pc),
    .o_pred_taken(m0_pred), .o_id_redirect(m0_redir),
    .i_ex_valid(i_ex_valid), .i_ex_branch(i_ex_branch), .i_ex_jump(i_ex_jump),
    .i_ex_linkReg(i_ex_linkReg), .i_ex_func3_0(i_ex_func3_0), .i_ex_func3_2(i_ex_func3_2),
    .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_ex_pc(i_ex_pc),
    .i_ex_pred_taken(i_ex_pred_taken),
    .o_pcSrc(m0_pcsrc), .o_flush(m0_flush), .o_branch_cnt(m0_bcnt), .o_mispred_cnt(m0_mcnt)
  );

  branch_pred_ctrl_unit #(.CNT_W(4)) u_c4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .i_id_branch(i_id_branch), .i_id_pc(i_id_pc),
    .o_pred_taken(c4_pred), .o_id_redirect(c4_redir),
    .i_ex_valid(i_ex_valid), .i_ex_branch(i_ex_branch), .i_ex_jump(i_ex_jump),
    .i_ex_linkReg(i_ex_linkReg), .i_ex_func3_0(i_ex_func3_0), .i_ex_func3_2(i_ex_func3_2),
    .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_ex_pc(i_ex_pc),
    .i_ex_pred_taken(i_ex_pred_taken),
    .o_pcSrc(c4_pcsrc), .o_flush(c4_flush), .o_branch_cnt(c4_bcnt), .o_mispred_cnt(c4_mcnt)
  );

  task automatic idle();
    i_stall = 0; i_id_branch = 0; i_id_pc = 0; i_ex_pc = 0;
    i_ex_valid = 0; i_ex_branch = 0; i_ex_jump = 0; i_ex_linkReg = 0;
    i_ex_func3_0 = 0; i_ex_func3_2 = 0; i_alu_result = 0; i_alu_zero = 0; i_ex_pred_taken = 0;
  endtask

  task automatic id_br(input logic [31:0] pc);
    i_id_branch = 1; i_id_pc = pc;
  endtask

  task automatic ex_br(input logic [31:0] pc, input logic f2, input logic f0,
                       input logic res, input logic zr, input logic pr);
    i_ex_valid = 1; i_ex_branch = 1; i_ex_jump = 0; i_ex_linkReg = 0; i_ex_pc = pc;
    i_ex_func3_2 = f2; i_ex_func3_0 = f0; i_alu_result = res; i_alu_zero = zr;
    i_ex_pred_taken = pr;
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst_n = 0; idle(); id_br(32'h40); #1;
    n_chk++; if (pred !== 1'b0)   begin n_fail++; $display("FAIL rst_pred got %b exp 0", pred); end
    n_chk++; if (redir !== 1'b0)  begin n_fail++; $display("FAIL rst_redir got %b exp 0", redir); end
    n_chk++; if (pcsrc !== 2'b00) begin n_fail++; $display("FAIL rst_pcsrc got %b exp 00", pcsrc); end
    n_chk++; if (flush !== 1'b0)  begin n_fail++; $display("FAIL rst_flush got %b exp 0", flush); end
    n_chk++; if (bcnt !== 32'd0)  begin n_fail++; $display("FAIL rst_bcnt got %0d exp 0", bcnt); end
    n_chk++; if (mcnt !== 32'd0)  begin n_fail++; $display("FAIL rst_mcnt got %0d exp 0", mcnt); end
    #11 i_rst_n = 1;
    tick();
  endtask

  task automatic test_mispredict();
    idle(); id_br(32'h40); ex_br(32'h40, 0, 0, 0, 1, 0); #1;
    n_chk++; if (pred !== 1'b0)   begin n_fail++; $display("FAIL mp_pred got %b exp 0", pred); end
    n_chk++; if (pcsrc !== 2'b01) begin n_fail++; $display("FAIL mp_pcsrc got %b exp 01", pcsrc); end
    n_chk++; if (flush !== 1'b1)  begin n_fail++; $display("FAIL mp_flush got %b exp 1", flush); end
    n_chk++; if (redir !== 1'b0)  begin n_fail++; $display("FAIL mp_redir got %b exp 0", redir); end
    tick();
    idle(); id_br(32'h40); #1;
    n_chk++; if (bcnt !== 32'd1) begin n_fail++; $display("FAIL mp_bcnt got %0d exp 1", bcnt); end
    n_chk++; if (mcnt !== 32'd1) begin n_fail++; $display("FAIL mp_mcnt got %0d exp 1", mcnt); end
    n_chk++; if (pred !== 1'b1)  begin n_fail++; $display("FAIL mp_pred_after got %b exp 1", pred); end
  endtask

  task automatic test_train();
    for (int k = 0; k < 2; k++) begin
      idle(); ex_br(32'h40, 0, 0, 0, 1, 1); #1;
      n_chk++; if (pcsrc !== 2'b00 || flush !== 1'b0)
        begin n_fail++; $display("FAIL tr_ok%0d got %b/%b exp 00/0", k, pcsrc, flush); end
      tick();
    end
    idle(); id_br(32'h40); #1;
    n_chk++; if (pred !== 1'b1)  begin n_fail++; $display("FAIL tr_pred got %b exp 1", pred); end
    n_chk++; if (redir !== 1'b1) begin n_fail++; $display("FAIL tr_redir got %b exp 1", redir); end
    n_chk++; if (bcnt !== 32'd3) begin n_fail++; $display("FAIL tr_bcnt got %0d exp 3", bcnt); end
    ex_br(32'h40, 0, 0, 0, 1, 1); #1;
    n_chk++; if (pcsrc !== 2'b00 || flush !== 1'b0 || redir !== 1'b1)
      begin n_fail++; $display("FAIL tr_correct got %b/%b/%b exp 00/0/1", pcsrc, flush, redir); end
    tick();
    n_chk++; if (mcnt !== 32'd1 || bcnt !== 32'd4)
      begin n_fail++; $display("FAIL tr_cnt got %0d/%0d exp 4/1", bcnt, mcnt); end
  endtask

  task automatic test_bne_recover();
    idle(); ex_br(32'h40, 0, 1, 0, 1, 1); #1;
    n_chk++; if (pcsrc !== 2'b11 || flush !== 1'b1)
      begin n_fail++; $display("FAIL bne_rec got %b/%b exp 11/1", pcsrc, flush); end
    tick();
    idle(); id_br(32'h40); #1;
    n_chk++; if (pred !== 1'b1) begin n_fail++; $display("FAIL bne_pred10 got %b exp 1", pred); end
    n_chk++; if (bcnt !== 32'd5 || mcnt !== 32'd2)
      begin n_fail++; $display("FAIL bne_cnt got %0d/%0d exp 5/2", bcnt, mcnt); end
    idle(); ex_br(32'h40, 0, 1, 0, 1, 1); tick();
    idle(); id_br(32'h40); #1;
    n_chk++; if (pred !== 1'b0) begin n_fail++; $display("FAIL bne_pred01 got %b exp 0", pred); end
    n_chk++; if (bcnt !== 32'd6 || mcnt !== 32'd3)
      begin n_fail++; $display("FAIL bne_cnt2 got %0d/%0d exp 6/3", bcnt, mcnt); end
  endtask

  task automatic test_saturate();
    idle(); ex_br(32'h48, 0, 1, 0, 1, 0); #1;
    n_chk++; if (pcsrc !== 2'b00 || flush !== 1'b0)
      begin n_fail++; $display("FAIL sat_nt got %b/%b exp 00/0", pcsrc, flush); end
    tick();
    idle(); ex_br(32'h48, 0, 1, 0, 1, 0); tick();
    idle(); ex_br(32'h48, 0, 0, 0, 1, 0); tick();
    idle(); id_br(32'h48); #1;
    n_chk++; if (pred !== 1'b0) begin n_fail++; $display("FAIL sat_floor got %b exp 0", pred); end
    n_chk++; if (bcnt !== 32'd9 || mcnt !== 32'd4)
      begin n_fail++; $display("FAIL sat_cnt got %0d/%0d exp 9/4", bcnt, mcnt); end
    idle(); ex_br(32'h40, 0, 0, 0, 1, 0); tick();
    idle(); id_br(32'h140); #1;
    n_chk++; if (pred !== 1'b1) begin n_fail++; $display("FAIL alias_pred got %b exp 1", pred); end
    id_br(32'h44); #1;
    n_chk++; if (pred !== 1'b0) begin n_fail++; $display("FAIL nbr_pred got %b exp 0", pred); end
  endtask

  task automatic test_jump();
    idle(); id_br(32'h40); i_ex_valid = 1; i_ex_jump = 1; i_ex_linkReg = 0; #1;
    n_chk++; if (pcsrc !== 2'b01 || flush !== 1'b1)
      begin n_fail++; $display("FAIL jal got %b/%b exp 01/1", pcsrc, flush); end
    n_chk++; if (pred !== 1'b1 || redir !== 1'b0)
      begin n_fail++; $display("FAIL jal_redir got %b/%b exp 1/0", pred, redir); end
    tick();
    i_ex_linkReg = 1; #1;
    n_chk++; if (pcsrc !== 2'b10 || flush !== 1'b1 || redir !== 1'b0)
      begin n_fail++; $display("FAIL jalr got %b/%b/%b exp 10/1/0", pcsrc, flush, redir); end
    tick();
    i_ex_valid = 0; #1;
    n_chk++; if (pcsrc !== 2'b00 || flush !== 1'b0 || redir !== 1'b1)
      begin n_fail++; $display("FAIL bubble got %b/%b/%b exp 00/0/1", pcsrc, flush, redir); end
    tick();
    n_chk++; if (bcnt !== 32'd10 || mcnt !== 32'd5)
      begin n_fail++; $display("FAIL jump_cnt got %0d/%0d exp 10/5", bcnt, mcnt); end
    n_chk++; if (pred !== 1'b1) begin n_fail++; $display("FAIL jump_tbl got %b exp 1", pred); end
  endtask

  task automatic test_stall();
    idle(); i_stall = 1; id_br(32'h44); ex_br(32'h44, 1, 1, 0, 0, 0); #1;
    n_chk++; if (pcsrc !== 2'b01 || flush !== 1'b1)
      begin n_fail++; $display("FAIL stl_out got %b/%b exp 01/1", pcsrc, flush); end
    tick(); tick();
    n_chk++; if (bcnt !== 32'd10 || mcnt !== 32'd5)
      begin n_fail++; $display("FAIL stl_cnt got %0d/%0d exp 10/5", bcnt, mcnt); end
    n_chk++; if (pred !== 1'b0) begin n_fail++; $display("FAIL stl_tbl got %b exp 0", pred); end
    i_stall = 0; #1;
    n_chk++; if (pred !== 1'b0) begin n_fail++; $display("FAIL nobypass got %b exp 0", pred); end
    tick();
    idle(); id_br(32'h44); #1;
    n_chk++; if (pred !== 1'b1) begin n_fail++; $display("FAIL unstl_tbl got %b exp 1", pred); end
    n_chk++; if (bcnt !== 32'd11 || mcnt !== 32'd6)
      begin n_fail++; $display("FAIL unstl_cnt got %0d/%0d exp 11/6", bcnt, mcnt); end
  endtask

  task automatic test_reset_mid();
    idle(); id_br(32'h40); #2;
    i_rst_n = 0; #1;
    n_chk++; if (bcnt !== 32'd0 || mcnt !== 32'd0)
      begin n_fail++; $display("FAIL mrst_cnt got %0d/%0d exp 0/0", bcnt, mcnt); end
    n_chk++; if (pred !== 1'b0) begin n_fail++; $display("FAIL mrst_pred got %b exp 0", pred); end
    #1 i_rst_n = 1;
    tick();
  endtask

  task automatic test_mode0_sat();
    for (int k = 0; k < 20; k++) begin
      idle(); id_br(32'h100 + 32'(4 * k)); ex_br(32'h100 + 32'(4 * k), 1, 0, 1, 0, 0); #1;
      n_chk++; if (m0_pred !== 1'b0 || m0_pcsrc !== 2'b01 || m0_flush !== 1'b1)
        begin n_fail++; $display("FAIL m0_blt%0d got %b/%b/%b exp 0/01/1", k, m0_pred, m0_pcsrc, m0_flush); end
      tick();
    end
    idle(); #1;
    n_chk++; if (m0_mcnt !== 32'd20 || m0_bcnt !== 32'd20)
      begin n_fail++; $display("FAIL m0_cnt got %0d/%0d exp 20/20", m0_bcnt, m0_mcnt); end
    n_chk++; if (bcnt !== 32'd20 || mcnt !== 32'd20)
      begin n_fail++; $display("FAIL m1_cnt got %0d/%0d exp 20/20", bcnt, mcnt); end
    n_chk++; if (c4_bcnt !== 4'd15) begin n_fail++; $display("FAIL c4_bsat got %0d exp 15", c4_bcnt); end
    n_chk++; if (c4_mcnt !== 4'd15) begin n_fail++; $display("FAIL c4_msat got %0d exp 15", c4_mcnt); end
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_train();
    test_bne_recover();
    test_saturate();
    test_jump();
    test_stall();
    test_reset_mid();
    test_mode0_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
